key_debounce_sync: RTL and testbench
====================================

// Module: key_debounce_sync
// PURPOSE
//  Synchronises and debounces the raw DE2-115 push-buttons (KEY[3:0], active-low) ahead of the Qsys system.
//  Its stable level drives button_pio_external_connection_export; single-cycle press/release pulses go to fabric logic.
//  One instance per input bank; a second instance with WIDTH=18 serves the slide switches.
// PARAMETERS
//  WIDTH        4           number of independent inputs
//  CLK_HZ       50000000    frequency of clk_io_clk_in_clk in Hz
//  DEBOUNCE_US  10000       required stable time in microseconds
//  ACTIVE_LOW   1           1: pressed = 0 (idle level 1); 0: pressed = 1 (idle level 0)
//  Derived: CNT_MAX = (CLK_HZ/1000000)*DEBOUNCE_US. Elaboration error if CNT_MAX < 2.
// PORTS
//  clk_io_clk_in_clk          in   1      single clock for the whole block
//  clk_io_clk_in_reset_reset  in   1      reset, synchronous, active-high
//  key_in                     in   WIDTH  raw asynchronous pad inputs
//  key_level                  out  WIDTH  debounced level, same polarity as key_in (feeds the PIO)
//  key_press                  out  WIDTH  1-cycle pulse when key_level moves idle->pressed
//  key_release                out  WIDTH  1-cycle pulse when key_level moves pressed->idle
//  key_capture                out  WIDTH  sticky press flags (see CONFIGURATION)
//  capture_clr                in   WIDTH  per-bit clear of key_capture
// BEHAVIOUR
//  - Reset (synchronous, active-high): both sync flops, key_level = idle level (ACTIVE_LOW ? 1 : 0). Counters = 0.
//    key_press = key_release = key_capture = 0. No pulse in the first cycle after reset, whatever key_in is.
//  - Sync: two-flop synchroniser per bit (sync1, sync2). No logic between the flops.
//  - Per-bit FSM, 2 states:
//    STABLE  -> CONFIRM when sync2 != key_level; counter loads 1.
//    CONFIRM -> STABLE  when sync2 == key_level (glitch); counter clears; no output change.
//    CONFIRM -> STABLE  when counter == CNT_MAX-1 and sync2 != key_level. key_level <= sync2; counter clears.
//    In the same registered update, key_press or key_release asserts for exactly one cycle.
//    Otherwise CONFIRM counts up by 1 per clock.
//  - Latency: a clean key_in step seen at edge 0 changes key_level and pulses at edge CNT_MAX+2.
//  - A bounce shorter than CNT_MAX cycles (measured at sync2) produces no change. A restart after a glitch begins a full count again.
//  - Counter width = $clog2(CNT_MAX). The counter never wraps; it is bounded by the CNT_MAX-1 compare.
//  - key_press and key_release for one bit are mutually exclusive. Bits are fully independent and may pulse in the same cycle.
//  - Reset asserted mid-CONFIRM: the count is abandoned and the state is the reset state above.
//    After reset, a held key needs a full CNT_MAX+2 cycles before it is reported.
// CONFIGURATION
//  KEY_DEBOUNCE_CAPTURE_EN defined:
//    key_capture[i] sets on key_press[i] and holds until capture_clr[i].
//    On the same cycle, set wins over clear.
//    This lets slow software poll presses without missing them.
//  Not defined: key_capture is constant 0, capture_clr is ignored, and no capture flops are built.
//  The port list is identical in both builds.
// STRUCTURE
//  - Package key_debounce_pkg:
//    function cnt_max(clk_hz, us), typedef of the bit FSM state enum {STABLE, CONFIRM}, function idle_level(active_low).
//  - Sub-module key_debounce_bit: one bit's synchroniser, FSM, counter and pulse outputs.
//  - The top module holds a generate loop of WIDTH instances plus the optional capture register.
// TESTING (bench: CLK_HZ=1000000, DEBOUNCE_US=8 -> CNT_MAX=8, WIDTH=4, ACTIVE_LOW=1)
//  1. Reset with key_in=4'b0000 held -> key_level=4'hF through reset, no pulse; key_level[3:0]=0 at CNT_MAX+2 = 10 cycles after release.
//     key_press=4'hF for 1 cycle at that point.
//  2. key_in[0] 1->0 clean step -> key_level[0]=0 and key_press[0]=1 exactly 10 cycles later, for one cycle only.
//     Step back 1 -> key_release[0] 10 cycles later.
//  3. key_in[1] low for 5 cycles, high 1, low 5, high -> key_level[1] stays 1; key_press[1] never asserts.
//  4. Reset asserted 4 cycles into a CONFIRM on bit 2 -> no pulse; key_level[2]=1; the full 10 cycles are needed after reset.
//  5. CAPTURE_EN: press bit 3 -> key_capture[3]=1 held.
//     capture_clr[3] pulsed on the same cycle as a new key_press[3] -> stays 1; clr alone -> 0 next cycle.
//  6. Bits 0 and 1 stepped on the same edge -> key_press=4'b0011 on the same cycle.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and elaboration helpers for key_debounce_sync.
//   deb_state_e  per-bit debounce FSM state
//   cnt_max()    stable-time requirement in clock cycles
//   idle_level() released level of an input for a given polarity
package key_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } deb_state_e;

  // Cycles of uninterrupted difference needed before a new level is accepted.
  function automatic int cnt_max(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

  function automatic logic idle_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// key_debounce_bit: one input's two-flop synchroniser, debounce FSM and
// press/release pulse generation.
//   clk    block clock
//   rst    synchronous active-high reset
//   din    raw asynchronous pad input
//   level  debounced level (same polarity as din)
//   press  1-cycle pulse on idle->pressed
//   rel    1-cycle pulse on pressed->idle
module key_debounce_bit
  import key_debounce_pkg::*;
#(
  parameter int   CNT_MAX = 8,
  parameter logic IDLE    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  deb_state_e    state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      level <= IDLE;
      state <= STABLE;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        STABLE: begin
          if (sync2 != level) begin
            state <= CONFIRM;
            cnt   <= CW'(1);
          end
        end
        CONFIRM: begin
          if (sync2 == level) begin
            // bounce back to the old level: abandon without any output change
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            // CNT_MAX consecutive differing samples (this one included)
            state <= STABLE;
            cnt   <= '0;
            level <= sync2;
            press <= (sync2 != IDLE);
            rel   <= (sync2 == IDLE);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: synchronises and debounces a bank of WIDTH raw inputs
// (push-buttons or slide switches).
//   clk_io_clk_in_clk          block clock
//   clk_io_clk_in_reset_reset  synchronous active-high reset
//   key_in       raw asynchronous pad inputs
//   key_level    debounced level, same polarity as key_in
//   key_press    1-cycle pulse per bit on idle->pressed
//   key_release  1-cycle pulse per bit on pressed->idle
//   key_capture  sticky press flags (only with KEY_DEBOUNCE_CAPTURE_EN)
//   capture_clr  per-bit clear of key_capture
// Build option: define KEY_DEBOUNCE_CAPTURE_EN to build the sticky capture
// register; otherwise key_capture is tied to 0 and capture_clr is ignored.
module key_debounce_sync
  import key_debounce_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_US = 10000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk_io_clk_in_clk,
  input  logic             clk_io_clk_in_reset_reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] key_capture,
  input  logic [WIDTH-1:0] capture_clr
);

  localparam int   CNT_MAX = cnt_max(CLK_HZ, DEBOUNCE_US);
  localparam logic IDLE    = idle_level(ACTIVE_LOW);

  generate
    if (CNT_MAX < 2) begin : g_bad_cfg
      $error("key_debounce_sync: CNT_MAX must be at least 2");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      key_debounce_bit #(
        .CNT_MAX (CNT_MAX),
        .IDLE    (IDLE)
      ) u_bit (
        .clk   (clk_io_clk_in_clk),
        .rst   (clk_io_clk_in_reset_reset),
        .din   (key_in[i]),
        .level (key_level[i]),
        .press (key_press[i]),
        .rel   (key_release[i])
      );
    end
  endgenerate

`ifdef KEY_DEBOUNCE_CAPTURE_EN
  logic [WIDTH-1:0] capture;

  // A press arriving in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_io_clk_in_clk) begin
    if (clk_io_clk_in_reset_reset) capture <= '0;
    else                           capture <= (capture & ~capture_clr) | key_press;
  end

  assign key_capture = capture;
`else
  logic unused_capture_clr;
  assign unused_capture_clr = ^capture_clr;
  assign key_capture = '0;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
module tb_key_debounce_sync;

  localparam int W       = 4;
  localparam int CNT_MAX = 8;  // 1 MHz * 8 us
  localparam int LAT     = CNT_MAX + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] key_in;
  logic [W-1:0] key_level, key_press, key_release, key_capture;
  logic [W-1:0] capture_clr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_debounce_sync #(
    .WIDTH       (W),
    .CLK_HZ      (1000000),
    .DEBOUNCE_US (8),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_io_clk_in_clk         (clk),
    .clk_io_clk_in_reset_reset (rst),
    .key_in                    (key_in),
    .key_level                 (key_level),
    .key_press                 (key_press),
    .key_release               (key_release),
    .key_capture               (key_capture),
    .capture_clr               (capture_clr)
  );

  // Reference: the FSM sees the input two clocks late; a bit's level flips
  // once the last CNT_MAX of those delayed samples all differ from it.
  logic [W-1:0] m_s1 = '1, m_s2 = '1;
  logic [W-1:0] win [CNT_MAX];
  logic [W-1:0] m_level = '1, m_press = '0, m_rel = '0, m_cap = '0;
  logic         all_diff;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '1; m_s2 = '1;
      for (int j = 0; j < CNT_MAX; j++) win[j] = '1;
      m_level = '1; m_press = '0; m_rel = '0; m_cap = '0;
    end else begin
`ifdef KEY_DEBOUNCE_CAPTURE_EN
      m_cap = (m_cap & ~capture_clr) | m_press;
`endif
      for (int j = CNT_MAX - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = m_s2;
      m_s2 = m_s1;
      m_s1 = key_in;
      m_press = '0; m_rel = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < CNT_MAX; j++)
          if (win[j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          if (m_level[b] == 1'b0) m_press[b] = 1'b1;
          else                    m_rel[b]   = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_level",   key_level,   m_level);
    chk("model_press",   key_press,   m_press);
    chk("model_release", key_release, m_rel);
    chk("model_capture", key_capture, m_cap);
  endtask

  task automatic step();
    @(negedge clk);
    chk_model();
  endtask

  // Input changed just now (between edges); expect exactly one pulse LAT edges later.
  task automatic expect_pulse(input string tag, input logic [W-1:0] ep, input logic [W-1:0] er);
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT) begin
        chk({tag, "_early_press"}, key_press, '0);
        chk({tag, "_early_rel"},   key_release, '0);
      end else begin
        chk({tag, "_press"}, key_press, ep);
        chk({tag, "_rel"},   key_release, er);
      end
    end
    step();
    chk({tag, "_press_1cyc"}, key_press, '0);
    chk({tag, "_rel_1cyc"},   key_release, '0);
  endtask

  initial begin
    rst = 1'b1; key_in = '0; capture_clr = '0;
    // 1. reset with all keys held pressed
    repeat (3) @(negedge clk);
    chk("rst_level", key_level, 4'hF);
    chk("rst_press", key_press, 4'h0);
    chk("rst_capture", key_capture, 4'h0);
    rst = 1'b0;
    expect_pulse("t1", 4'hF, 4'h0);
    chk("t1_level", key_level, 4'h0);
    key_in = 4'hF;
    expect_pulse("t1r", 4'h0, 4'hF);
    chk("t1r_level", key_level, 4'hF);

    // 2. clean step on bit 0, then back
    key_in = 4'b1110;
    expect_pulse("t2p", 4'b0001, 4'b0000);
    chk("t2p_level", key_level, 4'b1110);
    key_in = 4'hF;
    expect_pulse("t2r", 4'b0000, 4'b0001);

    // 3. bounce on bit 1 shorter than CNT_MAX
    key_in = 4'b1101; repeat (5) step();
    key_in = 4'hF;    step();
    key_in = 4'b1101; repeat (5) step();
    key_in = 4'hF;
    for (int k = 0; k < 2 * LAT; k++) begin
      step();
      chk("t3_level", key_level, 4'hF);
      chk("t3_press", key_press, 4'h0);
    end

    // 4. reset mid-confirm on bit 2
    key_in = 4'b1011;
    repeat (6) step();
    rst = 1'b1;
    repeat (2) step();
    chk("t4_rst_level", key_level, 4'hF);
    chk("t4_rst_press", key_press, 4'h0);
    rst = 1'b0;
    expect_pulse("t4", 4'b0100, 4'b0000);
    key_in = 4'hF;
    expect_pulse("t4r", 4'b0000, 4'b0100);

    // 5. capture on bit 3
    key_in = 4'b0111;
    expect_pulse("t5", 4'b1000, 4'b0000);
`ifdef KEY_DEBOUNCE_CAPTURE_EN
    chk("t5_cap_set", key_capture, 4'b1000);
`else
    chk("t5_cap_off", key_capture, 4'b0000);
`endif
    key_in = 4'hF;
    expect_pulse("t5r", 4'b0000, 4'b1000);
    key_in = 4'b0111;
    repeat (LAT) step();
    chk("t5_press2", key_press, 4'b1000);
    capture_clr = 4'b1000;
    step();
    capture_clr = 4'b0000;
`ifdef KEY_DEBOUNCE_CAPTURE_EN
    chk("t5_set_wins", key_capture, 4'b1000);
`else
    chk("t5_set_off", key_capture, 4'b0000);
`endif
    capture_clr = 4'b1000;
    step();
    capture_clr = 4'b0000;
    chk("t5_cleared", key_capture, 4'b0000);
    key_in = 4'hF;
    expect_pulse("t5r2", 4'b0000, 4'b1000);

    // 6. two bits stepped together
    key_in = 4'b1100;
    expect_pulse("t6", 4'b0011, 4'b0000);
    key_in = 4'hF;
    expect_pulse("t6r", 4'b0000, 4'b0011);

    // random bouncing, clears and occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk_model();
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 13) == 0) key_in[b] = ~key_in[b];
      capture_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
